gobou_bias_vec: RTL and testbench

Parametrised successor to the single-lane gobou bias stage. Adds a per-output-neuron bias to a LANE-wide vector of accumulated pixels, with optional saturation and ReLU, in a 2-stage valid-qualified pipeline. Biases live in a local BDEPTH-entry bank loaded over the breg write path. The bank is indexed by an internal channel pointer that advances every beat. Sits between the gobou MAC accumulators and the output writeback.

---
 rtl/gobou_bias_vec_if.sv | 35 +++
 rtl/gobou_bias_vec.sv | 119 +++++++++++
 tb/tb_gobou_bias_vec.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/gobou_bias_vec_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gobou_bias_vec_if : bias-load, mode and pixel-beat signal bundle |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface gobou_bias_vec_if #(
  parameter int DWIDTH  = 16,
  parameter int LANE    = 4,
  parameter int BAWIDTH = 4
);
  logic                     breg_we;
  logic [BAWIDTH-1:0]       breg_addr;
  logic [DWIDTH-1:0]        read_bias;
  logic [BAWIDTH:0]         ch_num;
  logic                     ch_start;
  logic                     relu_en;
  logic                     sat_en;
  logic                     in_valid;
  logic [LANE*DWIDTH-1:0]   pixel_in;
  logic                     out_valid;
  logic [LANE*DWIDTH-1:0]   pixel_out;

  modport master (
    output breg_we, breg_addr, read_bias, ch_num, ch_start,
           relu_en, sat_en, in_valid, pixel_in,
    input  out_valid, pixel_out
  );

  modport slave (
    input  breg_we, breg_addr, read_bias, ch_num, ch_start,
           relu_en, sat_en, in_valid, pixel_in,
    output out_valid, pixel_out
  );
endinterface
`default_nettype wire

// File: rtl/gobou_bias_vec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | gobou_bias_vec : LANE-wide bias add with sat/ReLU, 2-stage pipe  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module gobou_bias_vec #(
  parameter int DWIDTH  = 16,
  parameter int LANE    = 4,
  parameter int BDEPTH  = 16,
  parameter int BAWIDTH = 4
) (
  input  logic             clk,
  input  logic             xrst,
  gobou_bias_vec_if.slave  bus
);

  localparam logic [BAWIDTH:0] C_DEPTH = (BAWIDTH+1)'(BDEPTH);
  localparam logic [BAWIDTH:0] C_ONE   = (BAWIDTH+1)'(1);

  logic [DWIDTH-1:0]      bank_q [BDEPTH];
  logic [DWIDTH-1:0]      bank_d [BDEPTH];
  logic [BAWIDTH-1:0]     ptr_q, ptr_d;
  logic [BAWIDTH-1:0]     eff_ptr;
  logic [BAWIDTH:0]       eff_ch_num;

  logic [LANE*DWIDTH-1:0] lane1_q, lane1_d;
  logic [DWIDTH-1:0]      bias1_q, bias1_d;
  logic                   relu1_q, relu1_d;
  logic                   sat1_q, sat1_d;
  logic                   v1_q, v1_d;

  logic [LANE*DWIDTH-1:0] pixel_out_q, pixel_out_d;
  logic                   out_valid_q, out_valid_d;
  logic [LANE*DWIDTH-1:0] result;
  logic [DWIDTH:0]        sum;
  logic [DWIDTH-1:0]      lane_res;
  logic [DWIDTH-1:0]      lane_val;

  // Bank write and channel pointer; ch_start forces this beat onto entry 0
  always_comb begin
    bank_d = bank_q;
    if (bus.breg_we) bank_d[bus.breg_addr] = bus.read_bias;

    eff_ch_num = (bus.ch_num == '0 || bus.ch_num > C_DEPTH) ? C_DEPTH : bus.ch_num;
    eff_ptr    = bus.ch_start ? '0 : ptr_q;

    ptr_d = ptr_q;
    if (bus.in_valid) begin
      // >= also catches a pointer stranded past a shrunken ch_num
      if ({1'b0, eff_ptr} >= eff_ch_num - C_ONE) ptr_d = '0;
      else                                       ptr_d = eff_ptr + BAWIDTH'(1);
    end
  end

  // Stage 1 captures from bank_q so a same-cycle write is seen only by later beats
  always_comb begin
    lane1_d = lane1_q;
    bias1_d = bias1_q;
    relu1_d = relu1_q;
    sat1_d  = sat1_q;
    v1_d    = bus.in_valid;
    if (bus.in_valid) begin
      lane1_d = bus.pixel_in;
      bias1_d = bank_q[eff_ptr];
      relu1_d = bus.relu_en;
      sat1_d  = bus.sat_en;
    end
  end

  always_comb begin
    result   = '0;
    sum      = '0;
    lane_res = '0;
    lane_val = '0;
    for (int i = 0; i < LANE; i++) begin
      lane_val = lane1_q[i*DWIDTH +: DWIDTH];
      sum = {lane_val[DWIDTH-1], lane_val} + {bias1_q[DWIDTH-1], bias1_q};
      // Overflow when the two top bits of the widened sum disagree
      if (sat1_q && (sum[DWIDTH] ^ sum[DWIDTH-1]))
        lane_res = sum[DWIDTH] ? {1'b1, {(DWIDTH-1){1'b0}}} : {1'b0, {(DWIDTH-1){1'b1}}};
      else
        lane_res = sum[DWIDTH-1:0];
      if (relu1_q && lane_res[DWIDTH-1]) lane_res = '0;
      result[i*DWIDTH +: DWIDTH] = lane_res;
    end

    pixel_out_d = v1_q ? result : pixel_out_q;
    out_valid_d = v1_q;
  end

  always_ff @(posedge clk) begin
    if (xrst) begin
      for (int i = 0; i < BDEPTH; i++) bank_q[i] <= '0;
      ptr_q       <= '0;
      lane1_q     <= '0;
      bias1_q     <= '0;
      relu1_q     <= 1'b0;
      sat1_q      <= 1'b0;
      v1_q        <= 1'b0;
      pixel_out_q <= '0;
      out_valid_q <= 1'b0;
    end else begin
      bank_q      <= bank_d;
      ptr_q       <= ptr_d;
      lane1_q     <= lane1_d;
      bias1_q     <= bias1_d;
      relu1_q     <= relu1_d;
      sat1_q      <= sat1_d;
      v1_q        <= v1_d;
      pixel_out_q <= pixel_out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.pixel_out = pixel_out_q;
  assign bus.out_valid = out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_gobou_bias_vec.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_gobou_bias_vec : directed vectors with queued expectations    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_gobou_bias_vec;
  localparam int DW = 16;
  localparam int LN = 4;
  localparam int LW = DW * LN;

  typedef struct {
    logic [LW-1:0] data;
    int            cyc;
  } exp_t;

  logic clk;
  logic xrst;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];

  gobou_bias_vec_if #(.DWIDTH(DW), .LANE(LN), .BAWIDTH(4)) bus ();

  gobou_bias_vec #(.DWIDTH(DW), .LANE(LN), .BDEPTH(16), .BAWIDTH(4)) dut (
    .clk  (clk),
    .xrst (xrst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [LW-1:0] p4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  function automatic logic [LW-1:0] p1(input int a);
    return p4(a, a, a, a);
  endfunction

  // Every output beat is matched against the oldest expectation, including its cycle
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_out cyc=%0d got=%h required=no out_valid", cyc, bus.pixel_out);
      end else begin
        e = sb.pop_front();
        if (bus.pixel_out !== e.data || cyc != e.cyc) begin
          failures++;
          $display("FAIL beat_out got=%h@%0d required=%h@%0d", bus.pixel_out, cyc, e.data, e.cyc);
        end
      end
    end
  end

  task automatic idle();
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.ch_start = 1'b0;
    bus.breg_we  = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.ch_start  = 1'b0;
    bus.breg_we   = 1'b1;
    bus.breg_addr = a;
    bus.read_bias = d;
  endtask

  task automatic beat(input logic [LW-1:0] px, input logic [LW-1:0] ex,
                      input logic st, input logic relu, input logic sat, input logic push);
    @(posedge clk); #1;
    bus.breg_we  = 1'b0;
    bus.in_valid = 1'b1;
    bus.ch_start = st;
    bus.relu_en  = relu;
    bus.sat_en   = sat;
    bus.pixel_in = px;
    if (push) sb.push_back('{ex, cyc + 2});
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    xrst         = 1'b1;
    bus.in_valid = 1'b0;
    bus.ch_start = 1'b0;
    bus.breg_we  = 1'b0;
    @(posedge clk); #1;
    xrst = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    xrst          = 1'b1;
    bus.breg_we   = 1'b0;
    bus.breg_addr = '0;
    bus.read_bias = '0;
    bus.ch_num    = 5'd0;
    bus.ch_start  = 1'b0;
    bus.relu_en   = 1'b0;
    bus.sat_en    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pixel_in  = '0;
    repeat (3) @(posedge clk);
    #1 xrst = 1'b0;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || bus.pixel_out !== '0) begin
        failures++;
        $display("FAIL reset_idle got=%b/%h required=0/0", bus.out_valid, bus.pixel_out);
      end
    end

    // Reset clears the bank
    wr(4'd3, 16'd5);
    do_reset();
    bus.ch_num = 5'd4;
    beat(p1(0), p1(0), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) beat(p1(0), p1(0), 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // Channel sequencing across a wrap
    wr(4'd0, 16'd10);
    wr(4'd1, 16'hFFEC);
    wr(4'd2, 16'd30);
    bus.ch_num = 5'd3;
    beat(p1(100), p1(110), 1'b1, 1'b0, 1'b0, 1'b1);
    beat(p1(100), p1(80),  1'b0, 1'b0, 1'b0, 1'b1);
    beat(p1(100), p1(130), 1'b0, 1'b0, 1'b0, 1'b1);
    beat(p1(100), p1(110), 1'b0, 1'b0, 1'b0, 1'b1);
    beat(p1(100), p1(80),  1'b0, 1'b0, 1'b0, 1'b1);
    beat(p1(100), p1(130), 1'b0, 1'b0, 1'b0, 1'b1);
    idle();

    // Saturation versus wrap, mode changed between adjacent beats
    bus.ch_num = 5'd1;
    wr(4'd0, 16'h7000);
    beat(p1(16'h2000), p1(16'h7FFF), 1'b1, 1'b0, 1'b1, 1'b1);
    beat(p1(16'h2000), p1(16'h9000), 1'b0, 1'b0, 1'b0, 1'b1);
    wr(4'd0, 16'hFFFF);
    beat(p1(16'h8000), p1(16'h8000), 1'b1, 1'b0, 1'b1, 1'b1);

    // ReLU on and off
    wr(4'd0, 16'hFFCE);
    beat(p4(10, 60, -5, 50), p4(0, 10, 0, 0),     1'b1, 1'b1, 1'b0, 1'b1);
    beat(p4(10, 60, -5, 50), p4(-40, 10, -55, 0), 1'b1, 1'b0, 1'b0, 1'b1);

    // Write and read of entry 0 in the same cycle returns the old value
    wr(4'd0, 16'd1);
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.ch_start  = 1'b1;
    bus.relu_en   = 1'b0;
    bus.sat_en    = 1'b0;
    bus.pixel_in  = '0;
    bus.breg_we   = 1'b1;
    bus.breg_addr = 4'd0;
    bus.read_bias = 16'd9;
    sb.push_back('{p1(1), cyc + 2});
    beat(p1(0), p1(9), 1'b1, 1'b0, 1'b0, 1'b1);

    // Mid-pass reset: the third beat never emerges, bank ends up cleared
    wr(4'd0, 16'd7);
    bus.ch_num = 5'd4;
    beat(p1(1), p1(8),   1'b1, 1'b0, 1'b0, 1'b1);
    beat(p1(2), p1(-18), 1'b0, 1'b0, 1'b0, 1'b1);
    beat(p1(3), p1(0),   1'b0, 1'b0, 1'b0, 1'b0);
    do_reset();
    repeat (4) idle();
    bus.ch_num = 5'd1;
    beat(p1(100), p1(100), 1'b1, 1'b0, 1'b0, 1'b1);
    idle();

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
